// File: rtl/vpg_mode_sequencer.sv
// Pixel-PLL mode-change sequencer: holds the VGA timing generator, programs N/M/C0 over
// Avalon-MM, waits for stable lock, then releases. Optional readback check: VPG_SEQ_READBACK_EN.
module vpg_mode_sequencer #(
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 1024,
    parameter int CNT_W        = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mode,
    input  logic        mode_change,
    input  logic        pll_locked,
    input  logic        mgmt_waitrequest,
    input  logic [31:0] mgmt_readdata,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic        video_hold,
    output logic        busy,
    output logic        cfg_error,
    output logic [3:0]  active_mode
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WR, S_GAP, S_WAIT, S_DONE, S_FAIL, S_RD
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] LP_STABLE  = CNT_W'(LOCK_STABLE);

    state_t           r_state, w_next;
    logic [2:0]       r_idx, w_idx_next;
    logic [CNT_W-1:0] r_stable, w_stable_next, r_timeout, w_timeout_next;
    logic [3:0]       r_req, w_req_next, r_pend_mode;
    logic             r_pending, r_use_live, r_mc_d, r_lock_meta, r_lock_sync;
    logic             w_rise, w_mgmt_read_next;

    // Codes above 4 all select the 1080p settings.
    function automatic logic [3:0] clamp_mode(input logic [3:0] m);
        return (m > 4'd4) ? 4'd4 : m;
    endfunction

    function automatic logic [8:0] div_of(input logic [3:0] code, input logic [1:0] sel);
        logic [8:0] n, m, c;
        case (code)
            4'd0:    begin n = 9'd5;  m = 9'd126; c = 9'd50; end
            4'd1:    begin n = 9'd5;  m = 9'd108; c = 9'd40; end
            4'd2:    begin n = 9'd1;  m = 9'd13;  c = 9'd10; end
            4'd3:    begin n = 9'd5;  m = 9'd108; c = 9'd10; end
            default: begin n = 9'd20; m = 9'd297; c = 9'd5;  end
        endcase
        case (sel)
            2'd0:    return n;
            2'd1:    return m;
            default: return c;
        endcase
    endfunction

    // Divide 1 is bypass; otherwise high/low counts split the divide, bit 17 flags odd.
    function automatic logic [31:0] enc_div(input logic [8:0] d);
        logic [31:0] w;
        w = 32'd0;
        if (d == 9'd1) begin
            w = 32'h0001_0000;
        end else begin
            w[15:8] = 8'((d + 9'd1) >> 1);
            w[7:0]  = 8'(d >> 1);
            w[17]   = d[0];
        end
        return w;
    endfunction

    function automatic logic [5:0] addr_for(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'h00;
            3'd1:    return 6'h03;
            3'd2:    return 6'h04;
            3'd3:    return 6'h05;
            3'd4:    return 6'h02;
            default: return 6'h00;
        endcase
    endfunction

    function automatic logic [31:0] word_for(input logic [2:0] idx, input logic [3:0] code);
        case (idx)
            3'd1:    return enc_div(div_of(code, 2'd0));
            3'd2:    return enc_div(div_of(code, 2'd1));
            3'd3:    return enc_div(div_of(code, 2'd2));
            3'd4:    return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    assign w_rise = mode_change & ~r_mc_d;

    // Next-state, write index, lock counters and request selection.
    always_comb begin
        w_next         = r_state;
        w_idx_next     = r_idx;
        w_stable_next  = r_stable;
        w_timeout_next = r_timeout;
        w_req_next     = r_req;
        case (r_state)
            S_IDLE: begin
                if (w_rise) w_next = S_LOAD;
                else        w_next = S_IDLE;
            end
            S_LOAD: begin
                w_next     = S_WR;
                w_idx_next = 3'd0;
                w_req_next = clamp_mode(r_use_live ? mode : r_pend_mode);
            end
            S_WR: begin
                if (!mgmt_waitrequest) begin
`ifdef VPG_SEQ_READBACK_EN
                    if ((r_idx >= 3'd1) && (r_idx <= 3'd3)) w_next = S_RD;
                    else                                    w_next = S_GAP;
`else
                    w_next = S_GAP;
`endif
                end else begin
                    w_next = S_WR;
                end
            end
`ifdef VPG_SEQ_READBACK_EN
            S_RD: begin
                if (!mgmt_waitrequest) begin
                    if (mgmt_readdata[17:0] != mgmt_writedata[17:0]) w_next = S_FAIL;
                    else                                            w_next = S_GAP;
                end else begin
                    w_next = S_RD;
                end
            end
`endif
            S_GAP: begin
                if (r_idx == 3'd4) begin
                    w_next         = S_WAIT;
                    w_stable_next  = '0;
                    w_timeout_next = '0;
                end else begin
                    w_next     = S_WR;
                    w_idx_next = r_idx + 3'd1;
                end
            end
            S_WAIT: begin
                w_timeout_next = r_timeout + {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_lock_sync) w_stable_next = r_stable + {{(CNT_W-1){1'b0}}, 1'b1};
                else             w_stable_next = '0;
                if (w_stable_next == LP_STABLE)        w_next = S_DONE;
                else if (w_timeout_next == LP_TIMEOUT) w_next = S_FAIL;
                else                                   w_next = S_WAIT;
            end
            S_DONE, S_FAIL: begin
                if (r_pending || w_rise) w_next = S_LOAD;
                else                     w_next = S_IDLE;
            end
            default: w_next = S_LOAD;
        endcase
    end

`ifdef VPG_SEQ_READBACK_EN
    assign w_mgmt_read_next = (w_next == S_RD);
`else
    logic w_unused_rd;
    assign w_unused_rd      = ^mgmt_readdata;
    assign w_mgmt_read_next = 1'b0;
`endif

    // State, counters, request bookkeeping and registered bus/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_LOAD;
            r_idx          <= 3'd0;
            r_stable       <= '0;
            r_timeout      <= '0;
            r_req          <= 4'd4;
            r_pend_mode    <= 4'd0;
            r_pending      <= 1'b0;
            r_use_live     <= 1'b1;
            r_mc_d         <= 1'b0;
            r_lock_meta    <= 1'b0;
            r_lock_sync    <= 1'b0;
            mgmt_address   <= 6'd0;
            mgmt_writedata <= 32'd0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            video_hold     <= 1'b1;
            busy           <= 1'b1;
            cfg_error      <= 1'b0;
            active_mode    <= 4'd4;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_idx_next;
            r_stable    <= w_stable_next;
            r_timeout   <= w_timeout_next;
            r_req       <= w_req_next;
            r_mc_d      <= mode_change;
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            if (r_state == S_LOAD) r_use_live <= 1'b0;
            else                   r_use_live <= r_use_live;

            // An edge mid-sequence is remembered; at DONE/FAIL it is consumed by the restart.
            if ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL)) begin
                r_pending <= 1'b0;
                if (w_rise) r_pend_mode <= mode;
                else        r_pend_mode <= r_pend_mode;
            end else if (w_rise) begin
                r_pending   <= 1'b1;
                r_pend_mode <= mode;
            end else begin
                r_pending   <= r_pending;
                r_pend_mode <= r_pend_mode;
            end

            mgmt_write <= (w_next == S_WR);
            mgmt_read  <= w_mgmt_read_next;
            if ((w_next == S_WR) || (w_next == S_RD)) begin
                mgmt_address   <= addr_for(w_idx_next);
                mgmt_writedata <= word_for(w_idx_next, w_req_next);
            end else begin
                mgmt_address   <= 6'd0;
                mgmt_writedata <= 32'd0;
            end

            busy <= (w_next != S_IDLE);
            if (w_next == S_LOAD)                                 video_hold <= 1'b1;
            else if ((r_state == S_DONE) || (r_state == S_FAIL)) video_hold <= 1'b0;
            else                                                  video_hold <= video_hold;

            if (w_next == S_FAIL)      cfg_error <= 1'b1;
            else if (w_next == S_DONE) cfg_error <= 1'b0;
            else                       cfg_error <= cfg_error;

            if (r_state == S_DONE) active_mode <= r_req;
            else                   active_mode <= active_mode;
        end
    end

endmodule

// File: doc/vpg_mode_sequencer.md
Name: vpg_mode_sequencer

Overview:
- Sequences a video-mode change for the pattern-generator pixel PLL.
- Captures a mode request and holds the VGA timing generator in reset.
- Programs the PLL reconfiguration block's N/M/C0 counters over its Avalon-MM management port, starts reconfiguration, waits for stable lock, then releases the generator.
- Runs on the 50 MHz management clock, alongside pll_reconfig.

Parameters:
LOCK_TIMEOUT, 1000000, cycles allowed from START write until lock is stable (20 ms at 50 MHz)
LOCK_STABLE, 1024, consecutive synced-locked cycles required before release
CNT_W, 20, width of the lock/timeout counter

Ports:
clk  in  1  50 MHz management clock
reset  in  1  asynchronous, active-high reset
mode  in  4  requested mode: 0=640x480 (25.2), 1=720x480 (27), 2=1024x768 (65), 3=1280x1024 (108), 4=1920x1080 (148.5); 5-15 select mode 4 settings
mode_change  in  1  request; rising edge triggers a sequence
pll_locked  in  1  PLL lock, asynchronous; two-flop synchronised internally
mgmt_waitrequest  in  1  slave stall
mgmt_readdata  in  32  read data (used only with the optional feature)
mgmt_address  out  6  register address
mgmt_writedata  out  32  write data
mgmt_write  out  1  write strobe
mgmt_read  out  1  read strobe
video_hold  out  1  1 = hold the timing generator in reset
busy  out  1  sequence in progress
cfg_error  out  1  sticky: last sequence failed
active_mode  out  4  mode code (0-4) of the last completed sequence

Behaviour:
- Reset values:
  - Outputs: strobes 0, address 0, writedata 0, video_hold=1, busy=1, cfg_error=0, active_mode=4.
  - State: LOAD with mode sampled. Every reset runs one boot sequence.
- Divide table (N, M, C0):
  - mode0: 5, 126, 50
  - mode1: 5, 108, 40
  - mode2: 1, 13, 10
  - mode3: 5, 108, 10
  - mode4: 20, 297, 5
- Counter encoding for divide d:
  - d=1: data = 0x10000 (bypass).
  - Otherwise: [15:8] = ceil(d/2), [7:0] = floor(d/2), [17] = d odd.
  - C0 word has select bits [22:18] = 0.
- Write list, in order:
  1. addr 0x00 data 0 (waitrequest mode)
  2. addr 0x03 N word
  3. addr 0x04 M word
  4. addr 0x05 C0 word
  5. addr 0x02 data 1 (START)
- States:
  - IDLE: busy=0. A mode_change rising edge → LOAD.
  - LOAD: latch the mode into a request register, assert video_hold, busy=1 → WR with index 0.
  - WR: drive address/data, mgmt_write=1. Hold all three stable until a cycle with waitrequest=0. Next cycle: write=0 → GAP.
  - GAP: one idle cycle. Index < 4 → WR with index+1. Index = 4 → WAIT_LOCK with counters cleared.
  - WAIT_LOCK:
    - Timeout counter increments every cycle.
    - Stable counter increments while synced lock=1 and clears when it is 0.
    - Stable count = LOCK_STABLE → DONE.
    - Timeout count = LOCK_TIMEOUT → FAIL.
  - DONE: active_mode ← latched mode, cfg_error ← 0, video_hold ← 0 → IDLE.
  - FAIL: cfg_error ← 1, video_hold ← 0, active_mode unchanged → IDLE.
- Requests during a sequence:
  - A rising edge of mode_change while busy sets a pending flag; the latest mode is sampled at that edge.
  - On DONE/FAIL with pending set: go to LOAD instead of IDLE and clear pending; video_hold stays 1.
  - A rising edge in the same cycle as DONE counts as pending.
- Reset mid-transaction: strobes drop immediately (asynchronous); the sequence restarts from LOAD.
- Latency, from the edge to video_hold=0 with waitrequest=0 and lock present: 1 (LOAD) + 5×(WR+GAP) + LOCK_STABLE + 1 cycles.

Optional Feature:
- VPG_SEQ_READBACK_EN defined:
  - After each of writes 2-4, an RD state issues mgmt_read at the same address.
  - The read completes on the first cycle with waitrequest=0; readdata is sampled in that cycle.
  - Any mismatch against the written word in bits [17:0] → FAIL immediately, with no START write.
- Undefined: no reads are issued; mgmt_read is tied to 0.

Test Plan:
- Boot: release reset with mode=2, waitrequest=0, lock held 1 → writes in order 0x00/0, 0x03/0x10000, 0x04/0x20706, 0x05/0x0505, 0x02/1; video_hold falls LOSCK_STABLE+1 cycles after the GAP; active_mode=2.
- Mode 4 with waitrequest held 3 cycles on each write → M word 0x29594 stays stable for 4 cycles; write strobe lasts 4 cycles per write; ordering unchanged.
- Lock never asserts → cfg_error=1 exactly LOCK_TIMEOUT cycles after WAIT_LOCK entry; video_hold=0; active_mode keeps its previous value.
- mode_change edge for mode 0 during WAIT_LOCK of mode 3 → video_hold never drops between sequences; second sequence writes N=0x20302, M=0x3F3F, C0=0x1919; final active_mode=0.
- Reset asserted mid-WR → mgmt_write=0 in the same cycle; after release the full 5-write sequence reruns.
- With VPG_SEQ_READBACK_EN, readback of the M word returns a corrupted value → no START write is issued; cfg_error=1.
